// File: rtl/hssl_rx_link_monitor.sv
// -----------------------------------------------------------------------------
// hssl_rx_link_monitor
//
// Watches the 32-bit parallel receive word of a high-speed serial GT receiver,
// acquires word sync on K28.5 commas in byte 0, tracks a leaky error level while
// in sync, forwards data words, counts error words, and requests a GT datapath
// reset when the link stays out of sync for too long.
//
// Ports (all in the clk_in domain):
//   clk_in                 rx_usrclk2 clock
//   reset_in               synchronous active-high reset
//   rx_data_in[31:0]       GT receive word, byte 0 = [7:0]
//   rx_charisk_in[3:0]     per-byte K flag
//   rx_disperr_in[3:0]     per-byte disparity error
//   rx_encerr_in[3:0]      per-byte not-in-table error
//   rx_bufstatus_in        elastic buffer under/overflow
//   rx_reset_done_in       GT rx reset complete
//   clr_err_in             clear err_cnt_out
//   data_out[31:0]         received data word (holds when vld_out is 0)
//   vld_out                data_out valid, one cycle per DATA word in SYNC
//   sync_out               link in SYNC
//   err_cnt_out[15:0]      saturating error-word count
//   rx_reset_datapath_out  request to GT gtwiz_reset_rx_datapath
// -----------------------------------------------------------------------------
module hssl_rx_link_monitor #(
  parameter int SYNC_CNT    = 4,
  parameter int LOSS_ERR    = 4,
  parameter int GOOD_CNT    = 16,
  parameter int RESET_WAIT  = 1024,
  parameter int RESET_PULSE = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_disperr_in,
  input  logic [3:0]  rx_encerr_in,
  input  logic        rx_bufstatus_in,
  input  logic        rx_reset_done_in,
  input  logic        clr_err_in,
  output logic [31:0] data_out,
  output logic        vld_out,
  output logic        sync_out,
  output logic [15:0] err_cnt_out,
  output logic        rx_reset_datapath_out
);

  // Counter widths sized to hold the largest value each counter is compared to.
  localparam int CW = (SYNC_CNT > 1)    ? $clog2(SYNC_CNT + 1) : 1;
  localparam int WW = (RESET_WAIT > 2)  ? $clog2(RESET_WAIT)   : 1;
  localparam int LW = (LOSS_ERR > 1)    ? $clog2(LOSS_ERR + 1) : 1;
  localparam int GW = (GOOD_CNT > 1)    ? $clog2(GOOD_CNT + 1) : 1;
  localparam int PW = (RESET_PULSE > 2) ? $clog2(RESET_PULSE)  : 1;

  typedef enum logic [1:0] {
    ST_LOSS = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2,
    ST_RST  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] comma_q, comma_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [LW-1:0] level_q, level_d;
  logic [GW-1:0] good_q,  good_d;
  logic [PW-1:0] pulse_q, pulse_d;

  logic [31:0] data_q, data_d;
  logic        vld_q,  vld_d;
  logic        sync_q, sync_d;
  logic [15:0] errc_q, errc_d;
  logic        rstdp_q, rstdp_d;

  // Word classification and counter increments.
  logic          err_s, comma_s, data_s;
  logic          wait_exp_s;
  logic [CW-1:0] comma_inc_s;
  logic [WW-1:0] wait_inc_s;
  logic [LW-1:0] level_inc_s;
  logic [GW-1:0] good_inc_s;
  logic [PW-1:0] pulse_inc_s;

  // Classify the current receive word and precompute counter increments.
  always_comb begin
    err_s       = (|rx_encerr_in) | (|rx_disperr_in) | rx_bufstatus_in;
    comma_s     = ~err_s & (rx_charisk_in == 4'b0001) & (rx_data_in[7:0] == 8'hBC);
    data_s      = ~err_s & (rx_charisk_in == 4'b0000);
    wait_exp_s  = (wait_q == WW'(RESET_WAIT - 1));
    comma_inc_s = comma_q + CW'(1);
    wait_inc_s  = wait_q + WW'(1);
    level_inc_s = level_q + LW'(1);
    good_inc_s  = good_q + GW'(1);
    pulse_inc_s = pulse_q + PW'(1);
  end

  // Link FSM next-state and counter update.
  always_comb begin
    state_d = state_q;
    comma_d = comma_q;
    wait_d  = wait_q;
    level_d = level_q;
    good_d  = good_q;
    pulse_d = pulse_q;

    case (state_q)
      ST_RST: begin
        // The pulse always runs to completion, even if the GT is in reset.
        if (pulse_q == PW'(RESET_PULSE - 1)) begin
          state_d = ST_LOSS;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_inc_s;
        end
      end

      ST_LOSS, ST_ACQ: begin
        if (!rx_reset_done_in) begin
          // GT in reset: drop back and keep the wait counter parked at zero.
          state_d = ST_LOSS;
          comma_d = '0;
          wait_d  = '0;
          level_d = '0;
          good_d  = '0;
        end else if (wait_exp_s) begin
          // Expiry beats any comma arriving in the same cycle.
          state_d = ST_RST;
          comma_d = '0;
          wait_d  = '0;
          pulse_d = '0;
        end else begin
          wait_d = wait_inc_s;
          if (state_q == ST_LOSS) begin
            if (comma_s) begin
              state_d = ST_ACQ;
              comma_d = CW'(1);
            end else begin
              state_d = ST_LOSS;
            end
          end else begin
            if (err_s) begin
              state_d = ST_LOSS;
              comma_d = '0;
            end else if (comma_s) begin
              if (comma_inc_s == CW'(SYNC_CNT)) begin
                state_d = ST_SYNC;
                comma_d = '0;
                wait_d  = '0;
              end else begin
                comma_d = comma_inc_s;
              end
            end else begin
              comma_d = comma_q;
            end
          end
        end
      end

      ST_SYNC: begin
        if (!rx_reset_done_in) begin
          state_d = ST_LOSS;
          comma_d = '0;
          wait_d  = '0;
          level_d = '0;
          good_d  = '0;
        end else if (err_s) begin
          good_d = '0;
          if (level_inc_s == LW'(LOSS_ERR)) begin
            state_d = ST_LOSS;
            level_d = '0;
          end else begin
            level_d = level_inc_s;
          end
        end else begin
          // A full run of good words forgives one error, never below zero.
          if (good_inc_s == GW'(GOOD_CNT)) begin
            good_d = '0;
            if (level_q != LW'(0)) begin
              level_d = level_q - LW'(1);
            end else begin
              level_d = '0;
            end
          end else begin
            good_d = good_inc_s;
          end
        end
      end

      default: begin
        state_d = ST_LOSS;
        comma_d = '0;
        wait_d  = '0;
        level_d = '0;
        good_d  = '0;
        pulse_d = '0;
      end
    endcase
  end

  // Registered output next values.
  always_comb begin
    vld_d   = (state_q == ST_SYNC) & data_s;
    if (vld_d) begin
      data_d = rx_data_in;
    end else begin
      data_d = data_q;
    end
    sync_d  = (state_d == ST_SYNC);
    rstdp_d = (state_d == ST_RST);
    if (clr_err_in) begin
      errc_d = 16'h0000;
    end else if (err_s && rx_reset_done_in && (errc_q != 16'hFFFF)) begin
      errc_d = errc_q + 16'd1;
    end else begin
      errc_d = errc_q;
    end
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_LOSS;
      comma_q <= '0;
      wait_q  <= '0;
      level_q <= '0;
      good_q  <= '0;
      pulse_q <= '0;
      data_q  <= 32'h0000_0000;
      vld_q   <= 1'b0;
      sync_q  <= 1'b0;
      errc_q  <= 16'h0000;
      rstdp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      comma_q <= comma_d;
      wait_q  <= wait_d;
      level_q <= level_d;
      good_q  <= good_d;
      pulse_q <= pulse_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      sync_q  <= sync_d;
      errc_q  <= errc_d;
      rstdp_q <= rstdp_d;
    end
  end

  assign data_out              = data_q;
  assign vld_out               = vld_q;
  assign sync_out              = sync_q;
  assign err_cnt_out           = errc_q;
  assign rx_reset_datapath_out = rstdp_q;

endmodule

// File: tb/tb_hssl_rx_link_monitor.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hssl_rx_link_monitor: directed scenarios plus
// randomized word streams, every cycle compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_hssl_rx_link_monitor;

  localparam int SYNC_CNT    = 4;
  localparam int LOSS_ERR    = 4;
  localparam int GOOD_CNT    = 16;
  localparam int RESET_WAIT  = 1024;
  localparam int RESET_PULSE = 8;

  localparam int K_COMMA = 0;
  localparam int K_DATA  = 1;
  localparam int K_ERR   = 2;
  localparam int K_OTHER = 3;

  localparam int M_LOSS = 0;
  localparam int M_ACQ  = 1;
  localparam int M_SYNC = 2;
  localparam int M_RST  = 3;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [31:0] rx_data;
  logic [3:0]  rx_charisk, rx_disperr, rx_encerr;
  logic        rx_bufstatus, rx_reset_done, clr_err;
  logic [31:0] data_out;
  logic        vld_out, sync_out, rx_reset_datapath_out;
  logic [15:0] err_cnt_out;

  always #5 clk = ~clk;

  hssl_rx_link_monitor #(
    .SYNC_CNT(SYNC_CNT), .LOSS_ERR(LOSS_ERR), .GOOD_CNT(GOOD_CNT),
    .RESET_WAIT(RESET_WAIT), .RESET_PULSE(RESET_PULSE)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .rx_data_in(rx_data),
    .rx_charisk_in(rx_charisk), .rx_disperr_in(rx_disperr),
    .rx_encerr_in(rx_encerr), .rx_bufstatus_in(rx_bufstatus),
    .rx_reset_done_in(rx_reset_done), .clr_err_in(clr_err),
    .data_out(data_out), .vld_out(vld_out), .sync_out(sync_out),
    .err_cnt_out(err_cnt_out), .rx_reset_datapath_out(rx_reset_datapath_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: link mode plus plain integer counters.
  int          m_mode, m_commas, m_wait, m_level, m_good, m_pulse, m_err;
  logic [31:0] m_data;
  bit          m_vld;
  int          rst_high_cnt, first_rise, second_rise, tick_no;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit is_err, is_comma, is_data;
    is_err   = (rx_encerr != 4'd0) || (rx_disperr != 4'd0) || rx_bufstatus;
    is_comma = !is_err && rx_charisk == 4'b0001 && rx_data[7:0] == 8'hBC;
    is_data  = !is_err && rx_charisk == 4'b0000;
    if (reset_in) begin
      m_mode = M_LOSS; m_commas = 0; m_wait = 0; m_level = 0; m_good = 0;
      m_pulse = 0; m_err = 0; m_data = 32'd0; m_vld = 1'b0;
      return;
    end
    m_vld = (m_mode == M_SYNC) && is_data;
    if (m_vld) m_data = rx_data;
    if (clr_err) m_err = 0;
    else if (is_err && rx_reset_done && m_err < 65535) m_err++;
    if (m_mode == M_RST) begin
      m_pulse++;
      if (m_pulse == RESET_PULSE) begin m_mode = M_LOSS; m_pulse = 0; end
    end else if (!rx_reset_done) begin
      m_mode = M_LOSS; m_commas = 0; m_wait = 0; m_level = 0; m_good = 0;
    end else if (m_mode == M_SYNC) begin
      if (is_err) begin
        m_level++; m_good = 0;
        if (m_level == LOSS_ERR) begin m_mode = M_LOSS; m_level = 0; end
      end else begin
        m_good++;
        if (m_good == GOOD_CNT) begin
          m_good = 0;
          if (m_level > 0) m_level--;
        end
      end
    end else if (m_wait == RESET_WAIT - 1) begin
      m_mode = M_RST; m_wait = 0; m_commas = 0; m_pulse = 0;
    end else begin
      m_wait++;
      if (m_mode == M_LOSS) begin
        if (is_comma) begin m_mode = M_ACQ; m_commas = 1; end
      end else if (is_err) begin
        m_mode = M_LOSS; m_commas = 0;
      end else if (is_comma) begin
        m_commas++;
        if (m_commas == SYNC_CNT) begin m_mode = M_SYNC; m_commas = 0; m_wait = 0; end
      end
    end
  endtask

  // One clock: model follows the edge, then all outputs are compared.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tick_no++;
    if (rx_reset_datapath_out) rst_high_cnt++;
    check_eq("data_out", data_out, m_data);
    check_eq("vld_out", 32'(vld_out), 32'(m_vld));
    check_eq("sync_out", 32'(sync_out), 32'(m_mode == M_SYNC));
    check_eq("err_cnt_out", 32'(err_cnt_out), 32'(m_err));
    check_eq("rx_reset_datapath_out", 32'(rx_reset_datapath_out), 32'(m_mode == M_RST));
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k,
                           input logic [3:0] disp, input logic [3:0] enc, input logic bs);
    rx_data = d; rx_charisk = k; rx_disperr = disp; rx_encerr = enc; rx_bufstatus = bs;
    tick();
  endtask

  task automatic send(input int kind);
    logic [31:0] r;
    r = $urandom();
    case (kind)
      K_COMMA: send_word({r[31:8], 8'hBC}, 4'b0001, 4'd0, 4'd0, 1'b0);
      K_DATA:  send_word(r, 4'b0000, 4'd0, 4'd0, 1'b0);
      K_ERR: begin
        case (r[5:4])
          2'd0:    send_word(r, r[3:0], 4'd0, 4'b0001 << r[7:6], 1'b0);
          2'd1:    send_word(r, r[3:0], 4'b0001 << r[7:6], 4'd0, 1'b0);
          2'd2:    send_word(r, r[3:0], 4'd0, 4'd0, 1'b1);
          default: send_word(r, r[3:0], r[11:8] | 4'b0001, r[15:12], r[16]);
        endcase
      end
      default: send_word(r, 4'($urandom_range(2, 15)), 4'd0, 4'd0, 1'b0);
    endcase
  endtask

  task automatic do_reset(input int n);
    reset_in = 1'b1;
    for (int i = 0; i < n; i++) send(K_DATA);
    reset_in = 1'b0;
  endtask

  initial begin
    int w;
    reset_in = 1'b1; rx_reset_done = 1'b1; clr_err = 1'b0;
    rx_data = 32'd0; rx_charisk = 4'd0; rx_disperr = 4'd0; rx_encerr = 4'd0; rx_bufstatus = 1'b0;
    tick_no = 0; rst_high_cnt = 0;

    // Reset state.
    do_reset(3);
    check_eq("reset_sync", 32'(sync_out), 32'd0);
    check_eq("reset_errcnt", 32'(err_cnt_out), 32'd0);

    // Acquisition with four commas, then one data word.
    for (int i = 0; i < 4; i++) begin
      send(K_COMMA);
      check_eq("acq_sync", 32'(sync_out), (i == 3) ? 32'd1 : 32'd0);
    end
    send_word(32'h12345678, 4'b0000, 4'd0, 4'd0, 1'b0);
    check_eq("first_vld", 32'(vld_out), 32'd1);
    check_eq("first_data", data_out, 32'h12345678);

    // Error level: 3 errors, 16 good, then 2 errors.
    for (int i = 0; i < 3; i++) send(K_ERR);
    for (int i = 0; i < 16; i++) send(K_DATA);
    send(K_ERR);
    check_eq("level_keep_sync", 32'(sync_out), 32'd1);
    send_word(32'hA5A5A5A5, 4'b0000, 4'd0, 4'b0010, 1'b0);
    check_eq("level_drop_sync", 32'(sync_out), 32'd0);
    check_eq("level_drop_vld", 32'(vld_out), 32'd0);

    // Error in ACQ after two commas.
    clr_err = 1'b1; send(K_DATA); clr_err = 1'b0;
    check_eq("clr_errcnt", 32'(err_cnt_out), 32'd0);
    send(K_COMMA); send(K_COMMA);
    send_word(32'h000000BC, 4'b0001, 4'd0, 4'b0100, 1'b0);
    check_eq("acq_err_sync", 32'(sync_out), 32'd0);
    check_eq("acq_err_cnt", 32'(err_cnt_out), 32'd1);
    for (int i = 0; i < 3; i++) send(K_COMMA);
    check_eq("acq_restart_nosync", 32'(sync_out), 32'd0);
    send(K_COMMA);
    check_eq("acq_restart_sync", 32'(sync_out), 32'd1);

    // Wait-counter expiry and datapath reset pulse.
    do_reset(2);
    tick_no = 0; rst_high_cnt = 0; first_rise = -1; second_rise = -1;
    for (int i = 0; i < 2200; i++) begin
      w = rst_high_cnt;
      send(K_DATA);
      if (rst_high_cnt != w && first_rise < 0) first_rise = tick_no;
      else if (rst_high_cnt == RESET_PULSE + 1 && w == RESET_PULSE) second_rise = tick_no;
    end
    check_eq("rst_first_rise", 32'(first_rise), 32'd1024);
    check_eq("rst_second_rise", 32'(second_rise), 32'd2056);
    check_eq("rst_high_cycles", 32'(rst_high_cnt), 32'(2 * RESET_PULSE));

    // GT in reset: no datapath reset request, commas ignored.
    do_reset(2);
    rx_reset_done = 1'b0; rst_high_cnt = 0;
    for (int i = 0; i < 2000; i++) send(int'($urandom_range(0, 3)));
    check_eq("gt_reset_no_req", 32'(rst_high_cnt), 32'd0);
    rx_reset_done = 1'b1;
    for (int i = 0; i < 4; i++) send(K_COMMA);
    check_eq("gt_sync_up", 32'(sync_out), 32'd1);
    rx_reset_done = 1'b0;
    send(K_DATA);
    check_eq("gt_sync_drop", 32'(sync_out), 32'd0);
    rx_reset_done = 1'b1;

    // Randomized segments with varying comma density.
    for (int seg = 0; seg < 8; seg++) begin
      w = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 10 : 40);
      for (int i = 0; i < 600; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        rx_reset_done = ($urandom_range(0, 199) != 0) ? 1'b1 : ~rx_reset_done;
        clr_err  = ($urandom_range(0, 99) == 0);
        reset_in = ($urandom_range(0, 499) == 0);
        if (r < w)           send(K_COMMA);
        else if (r < w + 8)  send(K_ERR);
        else if (r < w + 15) send(K_OTHER);
        else                 send(K_DATA);
      end
    end
    clr_err = 1'b0; reset_in = 1'b0; rx_reset_done = 1'b1;

    // Error counter saturation and clear priority.
    do_reset(2);
    for (int i = 0; i < 65535; i++) send(K_ERR);
    check_eq("errcnt_full", 32'(err_cnt_out), 32'h0000FFFF);
    send(K_ERR);
    check_eq("errcnt_saturate", 32'(err_cnt_out), 32'h0000FFFF);
    clr_err = 1'b1; send(K_ERR); clr_err = 1'b0;
    check_eq("errcnt_clr_wins", 32'(err_cnt_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
